// File: rtl/bridge_cmd_ctrl.sv
// bridge_cmd_ctrl: converter command decoder and H-bridge / precharge sequencer.
//
// Decodes framed commands from the filtered parallel bus and drives the
// bridge legs, the precharge/start sequencer, the fan, the fault/break and
// stop outputs, and two status LEDs.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   strobe, bus        bus strobe (word taken on strobe falling edge) and word
//   fault              active-high fault inputs, gated by FAULT_MASK
//   o_top, o_bot       bridge leg gates, bit0 = leg 1
//   o_st, o_ch         start (precharge done) and charge relay outputs
//   o_fan, o_break     fan enable, fault break output
//   o_stop             sticky stop, set by fault[STOP_IDX]
//   o_plus..o_pause_n  mode indicators
//   fault_latched      sticky record of masked faults
//   led_ready          blinking status LED (fast blink in ERROR)
//   led_done           decoder idle and sequencer idle
//
// Decoder states:
//   state    | meaning
//   D_IDLE   | waiting for an opcode word
//   D_OPC    | opcode held in op_q, waiting for confirm word 0
//   D_EXT1   | got 7, expecting 0
//   D_EXT2   | got 7,0, expecting 7
//   D_EXT3   | got 7,0,7, expecting 0
//   D_EXT4   | got 7,0,7,0, expecting sub-command X
//   D_ERROR  | fault seen; only the extended clear frame is parsed
//
// Sequencer states:
//   state         | meaning
//   SEQ_IDLE      | no start in progress
//   SEQ_PRECHARGE | counting down to raising o_st
//   SEQ_SETTLE    | counting down to dropping o_ch

module bridge_cmd_ctrl #(
  parameter int unsigned         FREQ          = 50000000,
  parameter int unsigned         BUS_W         = 3,
  parameter int unsigned         N_FAULT       = 8,
  parameter logic [N_FAULT-1:0]  FAULT_MASK    = '1,
  parameter int unsigned         STOP_IDX      = 7,
  parameter int unsigned         PRECHARGE_CYC = 750000000,
  parameter int unsigned         SETTLE_CYC    = 50000000,
  parameter int unsigned         FRAME_TO      = 1000000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               strobe,
  input  logic [BUS_W-1:0]   bus,
  input  logic [N_FAULT-1:0] fault,
  output logic [3:0]         o_top,
  output logic [3:0]         o_bot,
  output logic               o_st,
  output logic               o_ch,
  output logic               o_fan,
  output logic               o_break,
  output logic               o_stop,
  output logic               o_plus,
  output logic               o_minus,
  output logic               o_pause_p,
  output logic               o_pause_n,
  output logic [N_FAULT-1:0] fault_latched,
  output logic               led_ready,
  output logic               led_done
);

  localparam int unsigned SEQ_MAX = (PRECHARGE_CYC > SETTLE_CYC) ? PRECHARGE_CYC - 1 : SETTLE_CYC - 1;
  localparam int SEQ_W = $clog2(SEQ_MAX) + 1;
  localparam int WD_W  = $clog2(FRAME_TO - 1) + 1;
  localparam int LED_W = $clog2(FREQ - 1) + 1;

  typedef enum logic [2:0] {D_IDLE, D_OPC, D_EXT1, D_EXT2, D_EXT3, D_EXT4, D_ERROR} dec_e;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_PRECHARGE, SEQ_SETTLE} seq_e;

  dec_e               dec_q, dec_d, home;
  seq_e               seq_q, seq_d;
  logic               err_q, err_d;
  logic [2:0]         op_q, op_d;
  logic [SEQ_W-1:0]   seq_tmr_q, seq_tmr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [LED_W-1:0]   led_tmr_q, led_tmr_d;
  logic               strobe_prev_q, strobe_prev_d;
  logic [3:0]         top_q, top_d, bot_q, bot_d;
  logic               st_q, st_d, ch_q, ch_d, fan_q, fan_d, brk_q, brk_d, stop_q, stop_d;
  logic               plus_q, plus_d, minus_q, minus_d, pp_q, pp_d, pn_q, pn_d;
  logic               led_q, led_d;
  logic [N_FAULT-1:0] flat_q, flat_d, mf;
  logic               strb_fall, word_ok, seq_busy, mode_wr;
  logic [2:0]         w, mode_sel;

  always_comb begin
    dec_d         = dec_q;
    seq_d         = seq_q;
    err_d         = err_q;
    op_d          = op_q;
    seq_tmr_d     = seq_tmr_q;
    wd_d          = wd_q;
    led_tmr_d     = led_tmr_q;
    strobe_prev_d = strobe;
    top_d         = top_q;
    bot_d         = bot_q;
    st_d          = st_q;
    ch_d          = ch_q;
    fan_d         = fan_q;
    brk_d         = brk_q;
    stop_d        = stop_q;
    plus_d        = plus_q;
    minus_d       = minus_q;
    pp_d          = pp_q;
    pn_d          = pn_q;
    led_d         = led_q;
    flat_d        = flat_q;
    mode_wr       = 1'b0;
    mode_sel      = 3'd0;
    strb_fall     = strobe_prev_q & ~strobe;
    word_ok       = ((bus >> 3) == '0);
    w             = bus[2:0];
    mf            = fault & FAULT_MASK;
    home          = err_q ? D_ERROR : D_IDLE;
    seq_busy      = (seq_q != SEQ_IDLE);

    // LED blink: fast period while a fault is outstanding.
    if (led_tmr_q == '0) begin
      led_d     = ~led_q;
      led_tmr_d = err_q ? LED_W'(FREQ / 8 - 1) : LED_W'(FREQ - 1);
    end else begin
      led_tmr_d = led_tmr_q - LED_W'(1);
    end

    case (seq_q)
      SEQ_PRECHARGE: begin
        if (seq_tmr_q == '0) begin
          st_d      = 1'b1;
          seq_d     = SEQ_SETTLE;
          seq_tmr_d = SEQ_W'(SETTLE_CYC - 1);
        end else begin
          seq_tmr_d = seq_tmr_q - SEQ_W'(1);
        end
      end
      SEQ_SETTLE: begin
        if (seq_tmr_q == '0) begin
          ch_d  = 1'b0;
          seq_d = SEQ_IDLE;
        end else begin
          seq_tmr_d = seq_tmr_q - SEQ_W'(1);
        end
      end
      default: ;
    endcase

    // Frame watchdog only runs while a frame is partially received.
    if (strb_fall) begin
      wd_d = WD_W'(FRAME_TO - 1);
    end else if (dec_q != D_IDLE && dec_q != D_ERROR) begin
      if (wd_q == '0) dec_d = home;
      else            wd_d  = wd_q - WD_W'(1);
    end

    if (strb_fall) begin
      dec_d = home;
      case (dec_q)
        D_IDLE: begin
          if (word_ok) begin
            if (w == 3'd6) begin
              // Shutdown aborts the sequencer at the opcode word already.
              seq_d     = SEQ_IDLE;
              seq_tmr_d = '0;
              op_d      = w;
              dec_d     = D_OPC;
            end else if (!seq_busy) begin
              op_d  = w;
              dec_d = (w == 3'd7) ? D_EXT1 : D_OPC;
            end
          end
        end
        D_ERROR: if (word_ok && w == 3'd7) dec_d = D_EXT1;
        D_OPC: begin
          if (word_ok && w == 3'd0) begin
            case (op_q)
              3'd0: mode_wr = 1'b1;
              3'd1, 3'd2, 3'd3, 3'd4: begin
                if (st_q && !ch_q) begin
                  mode_wr  = 1'b1;
                  mode_sel = op_q;
                end
              end
              3'd5: begin
                mode_wr   = 1'b1;
                fan_d     = 1'b1;
                st_d      = 1'b0;
                ch_d      = 1'b1;
                seq_d     = SEQ_PRECHARGE;
                seq_tmr_d = SEQ_W'(PRECHARGE_CYC - 1);
              end
              3'd6: begin
                mode_wr = 1'b1;
                st_d    = 1'b0;
                ch_d    = 1'b0;
                fan_d   = 1'b0;
              end
              default: ;
            endcase
          end
        end
        D_EXT1: if (word_ok && w == 3'd0) dec_d = D_EXT2;
        D_EXT2: if (word_ok && w == 3'd7) dec_d = D_EXT3;
        D_EXT3: if (word_ok && w == 3'd0) dec_d = D_EXT4;
        D_EXT4: begin
          if (word_ok && w == 3'd1 && !err_q && !st_q && !ch_q) begin
            mode_wr  = 1'b1;
            mode_sel = 3'd1;
          end
          if (word_ok && w == 3'd2 && mf == '0) begin
            flat_d = '0;
            brk_d  = 1'b0;
            stop_d = 1'b0;
            err_d  = 1'b0;
            dec_d  = D_IDLE;
          end
        end
        default: ;
      endcase
    end

    // Fault overrides anything decoded in the same cycle.
    if (mf != '0) begin
      flat_d    = flat_q | mf;
      mode_wr   = 1'b1;
      mode_sel  = 3'd0;
      fan_d     = 1'b1;
      st_d      = 1'b0;
      ch_d      = 1'b0;
      brk_d     = 1'b1;
      if (mf[STOP_IDX]) stop_d = 1'b1;
      seq_d     = SEQ_IDLE;
      seq_tmr_d = '0;
      dec_d     = D_ERROR;
      err_d     = 1'b1;
    end

    if (mode_wr) begin
      case (mode_sel)
        3'd1:    begin top_d = 4'b0001; bot_d = 4'b0010; end
        3'd2:    begin top_d = 4'b0010; bot_d = 4'b0001; end
        3'd3:    begin top_d = 4'b0100; bot_d = 4'b1000; end
        3'd4:    begin top_d = 4'b1000; bot_d = 4'b0100; end
        default: begin top_d = 4'b0000; bot_d = 4'b0000; end
      endcase
      plus_d  = (mode_sel == 3'd1);
      minus_d = (mode_sel == 3'd2);
      pp_d    = (mode_sel == 3'd3);
      pn_d    = (mode_sel == 3'd4);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dec_q         <= D_IDLE;
      seq_q         <= SEQ_IDLE;
      err_q         <= 1'b0;
      op_q          <= '0;
      seq_tmr_q     <= '0;
      wd_q          <= '0;
      led_tmr_q     <= '0;
      strobe_prev_q <= 1'b0;
      top_q         <= '0;
      bot_q         <= '0;
      st_q          <= 1'b0;
      ch_q          <= 1'b0;
      fan_q         <= 1'b0;
      brk_q         <= 1'b0;
      stop_q        <= 1'b0;
      plus_q        <= 1'b0;
      minus_q       <= 1'b0;
      pp_q          <= 1'b0;
      pn_q          <= 1'b0;
      led_q         <= 1'b0;
      flat_q        <= '0;
    end else begin
      dec_q         <= dec_d;
      seq_q         <= seq_d;
      err_q         <= err_d;
      op_q          <= op_d;
      seq_tmr_q     <= seq_tmr_d;
      wd_q          <= wd_d;
      led_tmr_q     <= led_tmr_d;
      strobe_prev_q <= strobe_prev_d;
      top_q         <= top_d;
      bot_q         <= bot_d;
      st_q          <= st_d;
      ch_q          <= ch_d;
      fan_q         <= fan_d;
      brk_q         <= brk_d;
      stop_q        <= stop_d;
      plus_q        <= plus_d;
      minus_q       <= minus_d;
      pp_q          <= pp_d;
      pn_q          <= pn_d;
      led_q         <= led_d;
      flat_q        <= flat_d;
    end
  end

  assign o_top         = top_q;
  assign o_bot         = bot_q;
  assign o_st          = st_q;
  assign o_ch          = ch_q;
  assign o_fan         = fan_q;
  assign o_break       = brk_q;
  assign o_stop        = stop_q;
  assign o_plus        = plus_q;
  assign o_minus       = minus_q;
  assign o_pause_p     = pp_q;
  assign o_pause_n     = pn_q;
  assign fault_latched = flat_q;
  assign led_ready     = led_q;
  assign led_done      = (dec_q == D_IDLE) && (seq_q == SEQ_IDLE);

endmodule

// File: tb/tb_bridge_cmd_ctrl.sv
// Testbench for bridge_cmd_ctrl: directed scenarios with literal expectations
// followed by randomized frames, all checked every cycle against a
// frame-list / absolute-cycle reference model.
module tb_bridge_cmd_ctrl;
  localparam int FREQ   = 64;
  localparam int PRE    = 20;
  localparam int SETTLE = 5;
  localparam int FTO    = 50;
  localparam logic [7:0] MASK = 8'h7F;
  localparam int STOP   = 6;

  logic clk = 0, rstn = 0, strobe = 0;
  logic [3:0] bus = 0;
  logic [7:0] fault = 0;
  logic [3:0] o_top, o_bot;
  logic o_st, o_ch, o_fan, o_break, o_stop, o_plus, o_minus, o_pause_p, o_pause_n;
  logic [7:0] fault_latched;
  logic led_ready, led_done;

  int n_cmp = 0, n_bad = 0;

  bridge_cmd_ctrl #(
    .FREQ(FREQ), .BUS_W(4), .N_FAULT(8), .FAULT_MASK(MASK), .STOP_IDX(STOP),
    .PRECHARGE_CYC(PRE), .SETTLE_CYC(SETTLE), .FRAME_TO(FTO)
  ) dut (
    .clk(clk), .rstn(rstn), .strobe(strobe), .bus(bus), .fault(fault),
    .o_top(o_top), .o_bot(o_bot), .o_st(o_st), .o_ch(o_ch), .o_fan(o_fan),
    .o_break(o_break), .o_stop(o_stop), .o_plus(o_plus), .o_minus(o_minus),
    .o_pause_p(o_pause_p), .o_pause_n(o_pause_n), .fault_latched(fault_latched),
    .led_ready(led_ready), .led_done(led_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   top_tab[5] = '{0, 1, 2, 4, 8};
  int   bot_tab[5] = '{0, 2, 1, 8, 4};
  int   m_mode;
  bit   m_st, m_ch, m_fan, m_brk, m_stop, m_led, m_err, m_prev, seq_on;
  logic [7:0] m_lat;
  int   frame[$];
  int   cyc, last_edge, seq_start, next_tog;

  task automatic model_reset();
    m_mode = 0; m_st = 0; m_ch = 0; m_fan = 0; m_brk = 0; m_stop = 0;
    m_led = 0; m_err = 0; m_prev = 0; seq_on = 0; m_lat = 0;
    frame.delete(); cyc = 0; last_edge = 0; seq_start = 0; next_tog = 0;
  endtask

  task automatic execute(int op, bit st0, bit ch0);
    case (op)
      0: m_mode = 0;
      1, 2, 3, 4: if (st0 && !ch0) m_mode = op;
      5: begin m_mode = 0; m_fan = 1; m_st = 0; m_ch = 1; seq_on = 1; seq_start = cyc; end
      6: begin m_mode = 0; m_st = 0; m_ch = 0; m_fan = 0; end
      default: ;
    endcase
  endtask

  task automatic handle_word(int w, bit busy0, bit st0, bit ch0, bit err0, logic [7:0] mf);
    int pat[4] = '{7, 0, 7, 0};
    int n;
    frame.push_back((w < 8) ? w : -1);
    n = frame.size();
    if (n == 1 && (frame[0] < 0 || (!err0 && busy0 && frame[0] != 6) || (err0 && frame[0] != 7))) begin
      frame.delete();
      return;
    end
    if (n == 1 && frame[0] == 6) seq_on = 0;
    if (frame[0] == 7) begin
      if (n <= 4) begin
        if (frame[n-1] != pat[n-1]) frame.delete();
      end else begin
        if (frame[4] == 1 && !err0 && !st0 && !ch0) m_mode = 1;
        if (frame[4] == 2 && mf == 0) begin m_lat = 0; m_brk = 0; m_stop = 0; m_err = 0; end
        frame.delete();
      end
    end else if (n == 2) begin
      if (frame[1] == 0) execute(frame[0], st0, ch0);
      frame.delete();
    end
  endtask

  task automatic model_step();
    logic [7:0] mf;
    bit fall, st0, ch0, busy0, err0;
    fall = m_prev && !strobe;
    m_prev = strobe;
    st0 = m_st; ch0 = m_ch; busy0 = seq_on; err0 = m_err;
    mf = fault & MASK;
    if (cyc == next_tog) begin
      m_led = !m_led;
      next_tog = cyc + (err0 ? FREQ / 8 : FREQ);
    end
    if (seq_on) begin
      if (cyc == seq_start + PRE) m_st = 1;
      if (cyc == seq_start + PRE + SETTLE) begin m_ch = 0; seq_on = 0; end
    end
    if (fall) begin
      last_edge = cyc;
      handle_word(int'(bus), busy0, st0, ch0, err0, mf);
    end else if (frame.size() > 0 && cyc - last_edge >= FTO) begin
      frame.delete();
    end
    if (mf != 0) begin
      m_lat = m_lat | mf; m_mode = 0; m_fan = 1; m_st = 0; m_ch = 0; m_brk = 1;
      if (mf[STOP]) m_stop = 1;
      seq_on = 0; frame.delete(); m_err = 1;
    end
    cyc++;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else       model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [26:0] got_v, exp_v;
    logic [3:0] et, eb;
    bit done;
    if (rstn) begin
      et = 4'(top_tab[m_mode]);
      eb = 4'(bot_tab[m_mode]);
      done = (frame.size() == 0) && !m_err && !seq_on;
      got_v = {o_top, o_bot, o_st, o_ch, o_fan, o_break, o_stop, o_plus, o_minus,
               o_pause_p, o_pause_n, fault_latched, led_ready, led_done};
      exp_v = {et, eb, m_st, m_ch, m_fan, m_brk, m_stop, m_mode == 1, m_mode == 2,
               m_mode == 3, m_mode == 4, m_lat, m_led, done};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got_v, exp_v);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic send(int w, int gap = 0);
    @(negedge clk); bus = 4'(w); strobe = 1;
    @(negedge clk); strobe = 0;
    @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_clear(int x);
    send(7); send(0); send(7); send(0); send(x);
  endtask

  task automatic led_period(output int per);
    logic l0;
    int c;
    l0 = led_ready; c = 0;
    while (led_ready == l0 && c < 200) begin @(negedge clk); c++; end
    l0 = led_ready; c = 0;
    while (led_ready == l0 && c < 200) begin @(negedge clk); c++; end
    per = c;
  endtask

  initial begin
    int per, r, gap;
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_top, o_bot, o_st, o_ch, o_fan, o_break, o_stop, o_plus,
                            o_minus, o_pause_p, o_pause_n, fault_latched, led_ready}, 0);
    rstn = 1;
    @(negedge clk);
    check("led_first_toggle", led_ready, 1);
    check("done_after_reset", led_done, 1);

    // start sequence
    send(5); send(0);
    check("start_ch", o_ch, 1);
    check("start_fan", o_fan, 1);
    check("start_st", o_st, 0);
    check("start_done", led_done, 0);
    repeat (19) @(negedge clk);
    check("st_before_pre", o_st, 0);
    @(negedge clk);
    check("st_after_pre", o_st, 1);
    repeat (4) @(negedge clk);
    check("ch_before_settle", o_ch, 1);
    @(negedge clk);
    check("ch_after_settle", o_ch, 0);
    check("done_after_seq", led_done, 1);

    // modes
    send(1); send(0);
    check("plus_top", o_top, 4'b0001);
    check("plus_bot", o_bot, 4'b0010);
    check("plus_flag", o_plus, 1);
    send(4); send(0);
    check("bn_top", o_top, 4'b1000);
    check("bn_bot", o_bot, 4'b0100);
    check("bn_flag", {o_plus, o_pause_n}, 2'b01);
    send(5); send(0);
    send(2); send(0);
    check("minus_in_pre_top", o_top, 0);
    check("minus_in_pre_flag", o_minus, 0);
    repeat (30) @(negedge clk);

    // abort mid-precharge
    send(5); send(0);
    repeat (5) @(negedge clk);
    send(6); send(0);
    check("abort_outs", {o_top, o_bot, o_st, o_ch, o_fan, o_plus, o_minus, o_pause_p, o_pause_n}, 0);
    repeat (30) @(negedge clk);
    check("abort_no_st", o_st, 0);

    // faults
    fault = 8'h80;
    repeat (3) @(negedge clk);
    check("masked_fault_brk", o_break, 0);
    check("masked_fault_lat", fault_latched, 0);
    fault = 8'h88;
    @(negedge clk);
    fault = 8'h80;
    check("fault_lat", fault_latched, 8'h08);
    check("fault_brk", o_break, 1);
    check("fault_fan", o_fan, 1);
    check("fault_legs", {o_top, o_bot}, 0);
    check("fault_stop", o_stop, 0);
    led_period(per);
    check("led_err_period", per, 8);
    fault = 8'h08;
    send_clear(2);
    check("clear_blocked_brk", o_break, 1);
    check("clear_blocked_done", led_done, 0);
    fault = 8'h00;
    send_clear(2);
    check("clear_lat", fault_latched, 0);
    check("clear_brk", o_break, 0);
    check("clear_done", led_done, 1);
    check("clear_fan_kept", o_fan, 1);
    fault = 8'h40;
    @(negedge clk);
    fault = 8'h00;
    check("stop_set", o_stop, 1);
    check("stop_lat", fault_latched, 8'h40);
    send_clear(2);
    check("stop_cleared", o_stop, 0);

    // watchdog and discharge
    send(7); send(0);
    check("wd_busy", led_done, 0);
    repeat (49) @(negedge clk);
    check("wd_not_yet", led_done, 0);
    @(negedge clk);
    check("wd_expired", led_done, 1);
    send_clear(1);
    check("dis_top", o_top, 4'b0001);
    check("dis_bot", o_bot, 4'b0010);
    check("dis_plus", o_plus, 1);
    send(9); send(0);
    check("invalid_word_kept", o_top, 4'b0001);

    // randomized frames
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      gap = $urandom_range(0, 3);
      if (r < 35) begin
        send($urandom_range(0, 6), gap);
        send(($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : 0, gap);
      end else if (r < 50) begin
        send(5, gap); send(0, $urandom_range(0, 30));
      end else if (r < 65) begin
        send(7, gap); send(($urandom_range(0, 7) == 0) ? 3 : 0, gap);
        send(7, gap); send(0, gap);
        send(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 2), gap);
      end else if (r < 73) begin
        send($urandom_range(0, 15), gap);
      end else if (r < 81) begin
        @(negedge clk); fault = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        fault = 0;
      end else if (r < 88) begin
        repeat ($urandom_range(45, 55)) @(negedge clk);
      end else begin
        send_clear(2);
      end
    end
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bridge_cmd_ctrl.md
Name: bridge_cmd_ctrl

Overview:
- Parametrised successor of the converter top-level control logic: decodes framed commands from the filtered parallel bus (strobe + data) and drives the H-bridge legs, precharge/start sequencer, fan and fault outputs.
- Adds configurable timing, a masked and latched fault vector, an extended-command fault-clear path, a frame watchdog, and a sticky stop output.
- Sits after the input filter instances. All inputs arrive already synchronised and glitch-filtered.

Parameters:
- FREQ, 50000000, clock frequency in Hz; sets the LED blink periods.
- BUS_W, 3, command bus width; must be >= 3; only the low 3 bits are decoded, upper bits must be 0 or the word counts as invalid.
- N_FAULT, 8, number of fault inputs.
- FAULT_MASK, all ones (N_FAULT bits), 1 = fault source enabled.
- STOP_IDX, 7, fault bit that also sets o_stop.
- PRECHARGE_CYC, 750000000, cycles from start acceptance until o_st rises.
- SETTLE_CYC, 50000000, cycles from o_st rising until o_ch falls.
- FRAME_TO, 1000000, max cycles between strobes inside a multi-word frame.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- strobe  in  1  bus strobe; word sampled on its 1->0 edge
- bus  in  BUS_W  command word
- fault  in  N_FAULT  active-high fault inputs
- o_top, o_bot  out  4 each  bridge leg gates, bit0 = leg 1
- o_st, o_ch, o_fan, o_break, o_stop  out  1 each
- o_plus, o_minus, o_pause_p, o_pause_n  out  1 each  mode indicators
- fault_latched  out  N_FAULT  sticky masked fault record
- led_ready, led_done  out  1 each

Behaviour:
- Clock and reset: clock clk; reset rstn, asynchronous, active-low. Every register and output resets to 0, decoder state goes to IDLE, and the sequencer goes to SEQ_IDLE.
- Strobe edge: previous strobe is registered; an edge is prev=1 and strobe=0. The word is taken from bus in the same cycle. Outputs update on the next clk edge (1-cycle latency).
- "Safe" means: o_top = o_bot = 0 and o_plus, o_minus, o_pause_p, o_pause_n = 0.
- Frames: opcode word followed by confirm word 0x0. If the confirm word is non-zero, the frame is dropped and the decoder returns to IDLE.
- Opcodes:
  - 0 pause: safe.
  - 1 plus: top=0001, bot=0010, o_plus=1.
  - 2 minus: top=0010, bot=0001, o_minus=1.
  - 3 ballast_p: top=0100, bot=1000, o_pause_p=1.
  - 4 ballast_n: top=1000, bot=0100, o_pause_n=1.
  - 5 start.
  - 6 shutdown.
  - 7 extended.
  - Each of 1-4 also clears the other three mode flags. Opcodes 1-4 apply only when o_st=1 and o_ch=0; otherwise the frame is ignored.
- Extended frames: 7,0,7,0,X.
  - X=1 discharge: applies the plus pattern only if o_st=0 and o_ch=0.
  - X=2 fault clear.
  - Any other X, or any wrong intermediate word, returns to IDLE with no action.
- Watchdog: in any non-IDLE decoder state, FRAME_TO cycles without a strobe edge returns the decoder to IDLE. The counter reloads on every edge.
- Start (confirmed opcode 5):
  - Applies safe and sets o_fan=1, o_st=0, o_ch=1.
  - Sequencer goes to PRECHARGE with timer = PRECHARGE_CYC-1.
  - When the timer reaches 0: o_st=1, state SETTLE, timer = SETTLE_CYC-1.
  - When the timer reaches 0 again: o_ch=0, state SEQ_IDLE.
  - While the sequencer is not idle, every opcode except 6 is consumed and then discarded at its opcode word.
- Shutdown (opcode 6):
  - Accepted at the opcode word even mid-sequence: sequencer goes to SEQ_IDLE immediately and the timer is zeroed.
  - On confirm 0: safe, and o_st = o_ch = o_fan = 0.
- Fault:
  - Active when any bit of (fault & FAULT_MASK) is set, evaluated every cycle. It has priority over any command in the same cycle.
  - On fault: fault_latched |= masked fault; safe; o_fan=1; o_st=o_ch=0; o_break=1; sequencer to SEQ_IDLE; decoder to ERROR.
  - fault[STOP_IDX] masked high sets o_stop.
- ERROR state:
  - Only the extended clear frame is parsed; all other frames return to ERROR.
  - Clear succeeds only if masked faults are all 0 in that cycle: fault_latched=0, o_break=0, o_stop=0, decoder to IDLE, o_fan unchanged.
  - If faults are still present, the clear is ignored and the state stays ERROR.
- LED:
  - led_timer counts down. At 0 it toggles led_ready and reloads FREQ-1, or FREQ/8-1 when in ERROR. The first toggle occurs in the first cycle after reset.
  - led_done = (decoder==IDLE) & (sequencer==SEQ_IDLE).
- Timer widths: $clog2 of the largest loaded value + 1; no wrap.

Test Plan (use PRECHARGE_CYC=20, SETTLE_CYC=5, FRAME_TO=50, FREQ=64):
- Start: send 5,0 -> next cycle o_fan=1, o_ch=1, o_st=0. o_st rises 20 cycles later. o_ch falls 5 cycles after that. led_done=0 throughout the sequence.
- Modes: after start completes, send 1,0 -> top=0001, bot=0010, o_plus=1. Then send 4,0 -> top=1000, bot=0100, o_pause_n=1, o_plus=0. Send 2,0 during the precharge phase -> no change.
- Abort: send 6 mid-precharge, then 0 -> all outputs 0, o_st never rises.
- Fault: with FAULT_MASK=8'h7F, assert fault[7] -> no effect. Then assert fault[3] for 1 cycle -> fault_latched=8'h08, o_break=1, o_fan=1, legs 0, led_ready period 8.
- Clear: send 7,0,7,0,2 while fault[3] is still high -> remains ERROR. Deassert fault[3] and resend -> fault_latched=0, o_break=0, led_done=1.
- Watchdog/discharge: send 7,0 then idle 50 cycles -> decoder returns to IDLE, no output change. Send 7,0,7,0,1 with o_st=0 -> top=0001, bot=0010, o_plus=1.
